// File: rtl/ck_mem_pkg.sv
// Shared memory-subsystem constants: default bus geometry and the response owner encoding.
package ck_mem_pkg;

  localparam int DATA_WHITH = 32;
  localparam int DATA_SIZE  = 8;
  localparam int ADDR_WHITH = 10;

  // Owner of the SRAM response in the cycle after a grant.
  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'b00;
  localparam owner_t OWN_IFU  = 2'b01;
  localparam owner_t OWN_LSU  = 2'b10;

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// Counts consecutive cycles the IFU has been denied the SRAM and flags when the
// IFU must be forced through ahead of the LSU.
module ram_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ifu_req_i,
  input  logic ifu_gnt_i,
  output logic force_ifu_o
);

  localparam int              CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear when IFU is served or idle, otherwise saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (rst || ifu_gnt_i || !ifu_req_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_ifu_o = (cnt_q == LIMIT);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates one single-port byte-write SRAM between the IFU and the LSU.
// LSU has fixed priority; the starvation counter forces an IFU grant after
// STARVE_LIMIT consecutive lost cycles. Read data returns one cycle after grant.
module ram_arbiter #(
  parameter int DATA_WHITH   = ck_mem_pkg::DATA_WHITH,
  parameter int DATA_SIZE    = ck_mem_pkg::DATA_SIZE,
  parameter int ADDR_WHITH   = ck_mem_pkg::ADDR_WHITH,
  parameter int DATA_BYTE    = DATA_WHITH / DATA_SIZE,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req,
  input  logic [ADDR_WHITH-1:0] ifu_addr,
  output logic                  ifu_gnt,
  output logic                  ifu_rvalid,
  output logic [DATA_WHITH-1:0] ifu_rdata,
  input  logic                  lsu_req,
  input  logic [DATA_BYTE-1:0]  lsu_we,
  input  logic [ADDR_WHITH-1:0] lsu_addr,
  input  logic [DATA_WHITH-1:0] lsu_wdata,
  output logic                  lsu_gnt,
  output logic                  lsu_rvalid,
  output logic [DATA_WHITH-1:0] lsu_rdata,
  output logic                  ram_cs,
  output logic [DATA_BYTE-1:0]  ram_we,
  output logic [ADDR_WHITH-1:0] ram_addr,
  output logic [DATA_WHITH-1:0] ram_wdata,
  input  logic [DATA_WHITH-1:0] ram_rdata
);

  import ck_mem_pkg::*;

  logic   force_ifu;
  owner_t own_q, own_d;

  ram_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .ifu_req_i  (ifu_req),
    .ifu_gnt_i  (ifu_gnt),
    .force_ifu_o(force_ifu)
  );

  // Same-cycle grant: LSU wins unless the IFU is starving; nothing issues in reset.
  always_comb begin
    lsu_gnt = lsu_req & ~(ifu_req & force_ifu) & ~rst;
    ifu_gnt = ifu_req & ~lsu_gnt & ~rst;
  end

  // Drive the SRAM bus from the winner; idle bus is all zeros.
  always_comb begin
    ram_cs    = ifu_gnt | lsu_gnt;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (lsu_gnt) begin
      ram_we    = lsu_we;
      ram_addr  = lsu_addr;
      ram_wdata = lsu_wdata;
    end else if (ifu_gnt) begin
      ram_addr  = ifu_addr;
    end
  end

  // Remember who was granted so the next-cycle SRAM data goes to the right port.
  always_comb begin
    own_d = OWN_NONE;
    if (ifu_gnt) own_d = OWN_IFU;
    if (lsu_gnt) own_d = OWN_LSU;
  end

  // Owner register.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_q <= OWN_NONE;
    end else begin
      own_q <= own_d;
    end
  end

  // Steer the response; a response falling into a reset cycle is dropped.
  always_comb begin
    ifu_rvalid = (own_q == OWN_IFU) & ~rst;
    lsu_rvalid = (own_q == OWN_LSU) & ~rst;
    ifu_rdata  = ifu_rvalid ? ram_rdata : '0;
    lsu_rdata  = lsu_rvalid ? ram_rdata : '0;
  end

endmodule
